// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the fifo_ctrl family.
//   FIFO_MODE_STD  : dout is registered and updates on an accepted read
//   FIFO_MODE_FWFT : head word is presented combinationally on dout
//   ptr_width()    : address width for a given power-of-two depth
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// DEPTH x WIDTH storage array: one synchronous write port, one asynchronous
// read port. Contents are not reset.
// Ports:
//   clk      : write clock (posedge)
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : read data (combinational from i_raddr)
// -----------------------------------------------------------------------------
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : fifo_mem

// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
// Parameterised synchronous FIFO with selectable read mode (standard or
// first-word-fall-through), occupancy count and almost-full/almost-empty
// watermarks.
//
// Optional feature macro: FIFO_ERR_FLAGS_EN
//   When defined, adds input err_clr and sticky outputs overflow/underflow.
//
// Ports:
//   clk, rst          : clock (posedge), asynchronous active-high reset
//   wr_en, din        : write request and data
//   full, almost_full : no free entries / count >= AF_LEVEL
//   rd_en, dout       : read (pop) request and read data
//   empty             : no valid entries
//   almost_empty      : count <= AE_LEVEL
//   count             : occupancy 0..DEPTH
//   err_clr           : (macro) clears overflow/underflow, wins over set
//   overflow          : (macro) sticky, wr_en seen while full
//   underflow         : (macro) sticky, rd_en seen while empty
//
// Handshake: a write is taken on a rising edge when wr_en=1 and full=0; a read
// is taken when rd_en=1 and empty=0. Requests against full/empty are dropped
// with no state change. full/empty are registered-state flags, so the
// producer/consumer may sample them at any point in the cycle.
// -----------------------------------------------------------------------------
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 32,
    parameter int FWFT          = FIFO_MODE_STD,
    parameter int AF_LEVEL      = DEPTH - 2,
    parameter int AE_LEVEL      = 2,
    parameter int POINTER_WIDTH = ptr_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       din,
    output logic                   full,
    output logic                   almost_full,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
    input  logic                   err_clr,
    output logic                   overflow,
    output logic                   underflow,
`endif
    output logic [POINTER_WIDTH:0] count
);

    localparam logic [POINTER_WIDTH:0] AF_LVL = (POINTER_WIDTH+1)'(AF_LEVEL);
    localparam logic [POINTER_WIDTH:0] AE_LVL = (POINTER_WIDTH+1)'(AE_LEVEL);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the addresses coincide.
    logic [POINTER_WIDTH:0] r_wr_ptr;
    logic [POINTER_WIDTH:0] r_rd_ptr;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_wr_acc;
    logic                   w_rd_acc;
    logic [WIDTH-1:0]       w_rd_data;
    logic [POINTER_WIDTH:0] w_count;

    assign w_full  = (r_wr_ptr[POINTER_WIDTH-1:0] == r_rd_ptr[POINTER_WIDTH-1:0])
                  && (r_wr_ptr[POINTER_WIDTH] != r_rd_ptr[POINTER_WIDTH]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_count = r_wr_ptr - r_rd_ptr;

    assign w_wr_acc = wr_en && !w_full;
    assign w_rd_acc = rd_en && !w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (POINTER_WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[POINTER_WIDTH-1:0]),
        .i_wdata (din),
        .i_raddr (r_rd_ptr[POINTER_WIDTH-1:0]),
        .o_rdata (w_rd_data)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Head word is always on the read port; rd_en only pops it.
            assign dout = w_rd_data;
        end else begin : g_std
            logic [WIDTH-1:0] r_dout;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_dout <= '0;
                end else if (w_rd_acc) begin
                    r_dout <= w_rd_data;
                end
            end
            assign dout = r_dout;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign count        = w_count;
    assign almost_full  = (w_count >= AF_LVL);
    assign almost_empty = (w_count <= AE_LVL);

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (err_clr) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full)  r_overflow  <= 1'b1;
            if (rd_en && w_empty) r_underflow <= 1'b1;
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule : fifo_ctrl

// File: tb/tb_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl
// Directed bench for fifo_ctrl: a standard-mode instance (WIDTH=8, DEPTH=8)
// and a first-word-fall-through instance of the same size share clk/rst.
// -----------------------------------------------------------------------------
module tb_fifo_ctrl;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int PW = 3;

    logic clk;
    logic rst;

    // standard-mode instance
    logic          s_wr_en, s_rd_en;
    logic [W-1:0]  s_din, s_dout;
    logic          s_full, s_afull, s_empty, s_aempty;
    logic [PW:0]   s_count;

    // FWFT instance
    logic          f_wr_en, f_rd_en;
    logic [W-1:0]  f_din, f_dout;
    logic          f_full, f_afull, f_empty, f_aempty;
    logic [PW:0]   f_count;

`ifdef FIFO_ERR_FLAGS_EN
    logic s_err_clr, s_ovf, s_unf;
    logic f_err_clr, f_ovf, f_unf;
`endif

    int n_checks;
    int n_fail;

    fifo_ctrl #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (s_wr_en),
        .din          (s_din),
        .full         (s_full),
        .almost_full  (s_afull),
        .rd_en        (s_rd_en),
        .dout         (s_dout),
        .empty        (s_empty),
        .almost_empty (s_aempty),
`ifdef FIFO_ERR_FLAGS_EN
        .err_clr      (s_err_clr),
        .overflow     (s_ovf),
        .underflow    (s_unf),
`endif
        .count        (s_count)
    );

    fifo_ctrl #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (f_wr_en),
        .din          (f_din),
        .full         (f_full),
        .almost_full  (f_afull),
        .rd_en        (f_rd_en),
        .dout         (f_dout),
        .empty        (f_empty),
        .almost_empty (f_aempty),
`ifdef FIFO_ERR_FLAGS_EN
        .err_clr      (f_err_clr),
        .overflow     (f_ovf),
        .underflow    (f_unf),
`endif
        .count        (f_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        s_wr_en = 0; s_rd_en = 0; s_din = '0;
        f_wr_en = 0; f_rd_en = 0; f_din = '0;
`ifdef FIFO_ERR_FLAGS_EN
        s_err_clr = 0; f_err_clr = 0;
`endif
        rst = 1'b1;
        #2;
        check("rst_empty",  32'(s_empty),  32'd1);
        check("rst_full",   32'(s_full),   32'd0);
        check("rst_count",  32'(s_count),  32'd0);
        check("rst_aempty", 32'(s_aempty), 32'd1);
        check("rst_afull",  32'(s_afull),  32'd0);
        check("rst_dout",   32'(s_dout),   32'd0);
        check("rst_f_empty", 32'(f_empty), 32'd1);
        tick();
        tick();
        rst = 1'b0;

        // ---------------- FWFT: head word falls through ----------------
        f_wr_en = 1; f_din = 8'h5A;
        tick();
        f_wr_en = 0;
        check("fwft_empty_low", 32'(f_empty), 32'd0);
        check("fwft_head",      32'(f_dout),  32'h5A);
        check("fwft_count1",    32'(f_count), 32'd1);
        tick();
        check("fwft_hold_head", 32'(f_dout),  32'h5A);
        f_rd_en = 1;
        tick();
        f_rd_en = 0;
        check("fwft_pop_empty", 32'(f_empty), 32'd1);
        f_wr_en = 1; f_din = 8'hC1;
        tick();
        f_din = 8'hC2;
        tick();
        f_wr_en = 0;
        check("fwft_head2", 32'(f_dout), 32'hC1);
        f_rd_en = 1;
        tick();
        f_rd_en = 0;
        check("fwft_next", 32'(f_dout), 32'hC2);
        check("fwft_cnt",  32'(f_count), 32'd1);

        // ---------------- STD: fill 0x11..0x18 ----------------
        for (int i = 0; i < D; i++) begin
            s_wr_en = 1; s_din = 8'(8'h11 + i);
            tick();
            check("fill_count",  32'(s_count), 32'(i + 1));
            check("fill_afull",  32'(s_afull), 32'((i + 1) >= 6));
            check("fill_aempty", 32'(s_aempty), 32'((i + 1) <= 2));
        end
        s_wr_en = 0;
        check("fill_full",  32'(s_full),  32'd1);
        check("fill_dout0", 32'(s_dout),  32'd0);

        // full write is dropped
        s_wr_en = 1; s_din = 8'hAA;
        tick();
        s_wr_en = 0;
        check("ovf_count", 32'(s_count), 32'd8);
        check("ovf_full",  32'(s_full),  32'd1);
`ifdef FIFO_ERR_FLAGS_EN
        check("ovf_flag", 32'(s_ovf), 32'd1);
        tick();
        check("ovf_sticky", 32'(s_ovf), 32'd1);
        s_err_clr = 1;
        tick();
        s_err_clr = 0;
        check("ovf_clr", 32'(s_ovf), 32'd0);
`endif

        // drain: dout follows each accepted read by one edge
        for (int i = 0; i < D; i++) begin
            s_rd_en = 1;
            tick();
            check("pop_dout",  32'(s_dout),  32'(8'h11 + i));
            check("pop_count", 32'(s_count), 32'(D - 1 - i));
        end
        s_rd_en = 0;
        check("drain_empty", 32'(s_empty), 32'd1);
        check("drain_full",  32'(s_full),  32'd0);

        // empty read is dropped; dout holds
        s_rd_en = 1;
        tick();
        s_rd_en = 0;
        check("unf_dout",  32'(s_dout),  32'h18);
        check("unf_count", 32'(s_count), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
        check("unf_flag", 32'(s_unf), 32'd1);
        s_err_clr = 1;
        tick();
        s_err_clr = 0;
        check("unf_clr", 32'(s_unf), 32'd0);
`endif

        // ---------------- wrap-around at constant occupancy ----------------
        for (int i = 0; i < 3; i++) begin
            s_wr_en = 1; s_din = 8'(8'h30 + i);
            tick();
        end
        check("wrap_pre_count", 32'(s_count), 32'd3);
        for (int k = 0; k < 20; k++) begin
            s_wr_en = 1; s_rd_en = 1; s_din = 8'(8'h33 + k);
            tick();
            check("wrap_count", 32'(s_count), 32'd3);
            check("wrap_dout",  32'(s_dout),  32'(8'h30 + k));
        end
        s_rd_en = 0;

        // two more writes -> count 5
        s_din = 8'h60;
        tick();
        s_din = 8'h61;
        tick();
        s_wr_en = 0;
        check("pre_rst_count", 32'(s_count), 32'd5);

        // async reset between edges clears state immediately
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", 32'(s_count), 32'd0);
        check("arst_empty", 32'(s_empty), 32'd1);
        check("arst_full",  32'(s_full),  32'd0);
        check("arst_dout",  32'(s_dout),  32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_count", 32'(s_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fifo_ctrl

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Parameterised synchronous FIFO, the successor to the basic 8x32 fifo used by the UART/IO path. It adds selectable read mode (standard registered vs. first-word-fall-through), an occupancy count, and programmable almost-full/almost-empty watermarks. It sits between the IO circuits (UART RX/TX, memory-mapped IO) and the CPU/MMIO side wherever a buffered byte/word stream is needed.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 32, number of entries; must be a power of two, >=2
FWFT, 0, 0 = standard mode (dout registered on read), 1 = first-word-fall-through
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
POINTER_WIDTH, $clog2(DEPTH), address width (derived; do not override)

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  write request
din  input  WIDTH  write data
full  output  1  no free entries
almost_full  output  1  count >= AF_LEVEL
rd_en  input  1  read (pop) request
dout  output  WIDTH  read data
empty  output  1  no valid entries
almost_empty  output  1  count <= AE_LEVEL
count  output  POINTER_WIDTH+1  current occupancy, 0..DEPTH

Behaviour:
- Reset: asynchronous, active-high. While rst high: rd_ptr=wr_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0) (effectively 0), dout=0 in standard mode. Storage contents not reset (don't-care); dout in FWFT mode is don't-care while empty.
- Pointers: POINTER_WIDTH+1 bits (extra wrap bit); address = low POINTER_WIDTH bits; wrap DEPTH-1 -> 0 naturally, no modulo.
- full = (ptr addresses equal, wrap bits differ); empty = (pointers fully equal). count = wr_ptr - rd_ptr. All flags derived from registered state: they reflect the post-edge state; no combinational path from wr_en/rd_en to any flag.
- Write accepted iff wr_en && !full at the edge; din stored at wr_ptr, wr_ptr+1.
- Read accepted iff rd_en && !empty at the edge; rd_ptr+1.
- Full write and empty read are ignored: no pointer change, no data change.
- Simultaneous accepted read and write: both pointers advance, count unchanged. When full, write is rejected even if a read is accepted the same cycle; when empty, read is rejected even if a write is accepted (no bypass).
- Standard mode (FWFT=0): dout registered; updates to mem[rd_ptr] on the edge a read is accepted, 1-cycle latency; holds last value otherwise. Write at edge N -> empty low after N -> rd_en at N+1 -> dout valid after N+1.
- FWFT mode (FWFT=1): dout = mem[rd_ptr] combinationally while !empty; head word visible 1 cycle after its write edge; rd_en acts as acknowledge/pop.
- Reset mid-operation: immediately clears pointers/flags; any in-flight read/write in that cycle is discarded.

Optional Feature:
Macro FIFO_ERR_FLAGS_EN. Defined: adds input err_clr (1) and outputs overflow (1), underflow (1). overflow sets sticky on any edge with wr_en && full; underflow on rd_en && empty; both cleared by rst or err_clr (err_clr takes priority over set in the same cycle). Not defined: ports absent, rejected requests silently ignored, behaviour otherwise identical.

Decomposition:
- Package fifo_pkg: read-mode constants FIFO_MODE_STD=0, FIFO_MODE_FWFT=1; helper function for pointer width.
- One sub-module: fifo_mem (DEPTH x WIDTH storage, one synchronous write port, one asynchronous read port); fifo_ctrl owns pointers, flags and dout register.

Test Plan:
- WIDTH=8, DEPTH=8, STD: reset, write 0x11..0x18 -> full=1, count=8, almost_full=1 at count 6; pop 8 -> dout 0x11..0x18 one cycle after each rd_en, then empty=1.
- Full write: with FIFO full, wr_en din=0xAA -> count stays 8, later reads never return 0xAA; with FIFO_ERR_FLAGS_EN, overflow=1 until err_clr pulse.
- Empty read: rd_en on empty -> dout holds previous value, count=0; underflow=1 when macro defined.
- Wrap-around: 20 write/read cycles at count~3, simultaneous wr_en/rd_en -> count constant at 3, data order preserved across pointer wrap.
- FWFT=1: write 0x5A to empty FIFO -> next cycle empty=0, dout=0x5A without rd_en; rd_en -> empty=1.
- Async reset asserted mid-cycle with count=5 -> empty=1, count=0, full=0 immediately, without waiting for clk edge.
